// File: rtl/ddr3_port_arb.sv
// Two-port arbiter in front of a Xilinx MIG user interface; read tags route returning data to the issuing port.
// Optional DDR3_ARB_RR_EN: round-robin on contention (default build: fixed priority, port 0 wins).
module ddr3_port_arb #(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned TAG_DEPTH = 32
) (
    input  logic              ui_clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    output logic              app_en,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic [1:0]        req,
    input  logic [1:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    output logic [1:0]        gnt,
    output logic [1:0]        wbeat,
    output logic [1:0]        rd_valid,
    output logic [1:0]        done,
    output logic              tag_err
);

    localparam int unsigned TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W  = TAG_AW + 1;
    localparam logic [2:0]  CMD_WR = 3'd0;
    localparam logic [2:0]  CMD_RD = 3'd1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARB,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                port_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [1:0]          gnt_q;

    logic                any_req;
    logic                winner;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic                sel_wr;
    logic                grant;
    logic                beat;
    logic                push;
    logic                pop;
    logic [1:0]          port_oh;

    logic [TAG_DEPTH-1:0] tag_mem;
    logic [TAG_AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     tag_cnt;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 head;
    logic                 tag_err_q;

    assign any_req = |req;

`ifdef DDR3_ARB_RR_EN
    // Last-granted port; starts at port 1 so port 0 wins the first contention.
    logic last_q;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= winner;
        end
    end

    assign winner = (req == 2'b11) ? ~last_q : req[1];
`else
    assign winner = ~req[0];
`endif

    assign sel_addr = winner ? req_addr1 : req_addr0;
    assign sel_len  = winner ? req_len1  : req_len0;
    assign sel_wr   = winner ? req_wr[1] : req_wr[0];
    assign port_oh  = port_q ? 2'b10 : 2'b01;

    assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign pop       = app_rd_data_valid && !tag_empty;
    assign head      = tag_mem[rd_ptr];

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and MIG strobes; a read may issue into a full FIFO when a pop frees a slot.
    always_comb begin
        state_d      = state_q;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        app_cmd      = CMD_WR;
        grant        = 1'b0;
        beat         = 1'b0;
        push         = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_calib_complete) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (any_req) begin
                    grant = 1'b1;
                    if (sel_len == '0) begin
                        state_d = ST_DONE;
                    end else if (sel_wr) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (app_rdy && app_wdf_rdy) begin
                    app_en       = 1'b1;
                    app_wdf_wren = 1'b1;
                    app_wdf_end  = 1'b1;
                    beat         = 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                app_cmd = CMD_RD;
                if (app_rdy && (!tag_full || pop)) begin
                    app_en = 1'b1;
                    push   = 1'b1;
                    beat   = 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Burst context captured at grant; address walks by one 8-word beat.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            gnt_q  <= 2'b00;
        end else begin
            if (grant) begin
                port_q <= winner;
                addr_q <= sel_addr;
                cnt_q  <= sel_len;
                gnt_q  <= winner ? 2'b10 : 2'b01;
            end else if (beat) begin
                addr_q <= addr_q + ADDR_W'(8);
                cnt_q  <= cnt_q - LEN_W'(1);
            end
            if (state_q == ST_DONE) begin
                gnt_q <= 2'b00;
            end
        end
    end

    // Read tag FIFO: one port-ID bit per outstanding read command.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_mem   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_cnt   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= port_q;
                wr_ptr          <= wr_ptr + TAG_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + TAG_AW'(1);
            end
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
            if (app_rd_data_valid && tag_empty) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign app_addr = addr_q;
    assign gnt      = gnt_q;
    assign done     = (state_q == ST_DONE) ? port_oh : 2'b00;
    assign wbeat    = app_wdf_wren ? port_oh : 2'b00;
    assign rd_valid = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
    assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_ddr3_port_arb.sv
// Directed cycle-by-cycle vectors for ddr3_port_arb plus hand-written sequences for
// contention, tag-FIFO back-pressure and mid-burst reset.
module tb_ddr3_port_arb;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned NVEC   = 24;

    logic              ui_clk = 1'b0;
    logic              rst_n;
    logic              init_calib_complete;
    logic              app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic              app_en, app_wdf_wren, app_wdf_end;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [1:0]        req, req_wr;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic [LEN_W-1:0]  req_len0, req_len1;
    logic [1:0]        gnt, wbeat, rd_valid, done;
    logic              tag_err;

    int checks = 0;
    int errors = 0;

    ddr3_port_arb #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TAG_DEPTH(32)) dut (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
        .app_en(app_en), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_cmd(app_cmd), .app_addr(app_addr),
        .req(req), .req_wr(req_wr), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_len0(req_len0), .req_len1(req_len1),
        .gnt(gnt), .wbeat(wbeat), .rd_valid(rd_valid), .done(done), .tag_err(tag_err)
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct {
        logic              calib;
        logic [1:0]        req, wr;
        logic [ADDR_W-1:0] a0, a1;
        logic [LEN_W-1:0]  l0, l1;
        logic              rdy, wdf, rdv;
        logic              en, wren;
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        gnt, wbeat, rdo, done;
        logic              terr;
    } vec_t;

    vec_t vec [NVEC];

    function automatic vec_t mk(
        input logic calib, input logic [1:0] rq, input logic [1:0] wr,
        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
        input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
        input logic rdy, input logic wdf, input logic rdv,
        input logic en, input logic wren, input logic [2:0] cmd,
        input logic [ADDR_W-1:0] addr, input logic [1:0] g, input logic [1:0] wb,
        input logic [1:0] rdo, input logic [1:0] dn, input logic terr);
        vec_t v;
        v.calib = calib; v.req = rq; v.wr = wr; v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1;
        v.rdy = rdy; v.wdf = wdf; v.rdv = rdv; v.en = en; v.wren = wren; v.cmd = cmd;
        v.addr = addr; v.gnt = g; v.wbeat = wb; v.rdo = rdo; v.done = dn; v.terr = terr;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic step();
        @(negedge ui_clk);
    endtask

    task automatic chk_idle(input string nm, input int row);
        chk({nm, " gnt"}, row, 32'(gnt), 32'h0);
        chk({nm, " app_en"}, row, 32'(app_en), 32'h0);
        chk({nm, " wren"}, row, 32'(app_wdf_wren), 32'h0);
        chk({nm, " wend"}, row, 32'(app_wdf_end), 32'h0);
        chk({nm, " cmd"}, row, 32'(app_cmd), 32'h0);
        chk({nm, " addr"}, row, 32'(app_addr), 32'h0);
        chk({nm, " wbeat"}, row, 32'(wbeat), 32'h0);
        chk({nm, " rd_valid"}, row, 32'(rd_valid), 32'h0);
        chk({nm, " done"}, row, 32'(done), 32'h0);
        chk({nm, " tag_err"}, row, 32'(tag_err), 32'h0);
    endtask

    initial begin
        int          ncmd;
        int          nb;
        int          ndone;
        logic [1:0]  seen [3];
        logic [1:0]  exp_g [3];
        logic        hit;

        // calib, req, wr, a0, a1, l0, l1, rdy, wdf, rdv | en, wren, cmd, addr, gnt, wbeat, rd_valid, done, tag_err
        vec[0]  = mk(0, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h0,       2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[1]  = mk(0, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h0,       2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[2]  = mk(1, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h0,       2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[3]  = mk(0, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h0,       2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[4]  = mk(0, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  1, 1, 0, 28'h100,     2'b01, 2'b01, 2'b00, 2'b00, 0);
        vec[5]  = mk(0, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 0, 0,  0, 0, 0, 28'h108,     2'b01, 2'b00, 2'b00, 2'b00, 0);
        vec[6]  = mk(0, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  1, 1, 0, 28'h108,     2'b01, 2'b01, 2'b00, 2'b00, 0);
        vec[7]  = mk(0, 2'b01, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  1, 1, 0, 28'h110,     2'b01, 2'b01, 2'b00, 2'b00, 0);
        vec[8]  = mk(0, 2'b00, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  1, 1, 0, 28'h118,     2'b01, 2'b01, 2'b00, 2'b00, 0);
        vec[9]  = mk(0, 2'b00, 2'b01, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h120,     2'b01, 2'b00, 2'b00, 2'b01, 0);
        vec[10] = mk(0, 2'b00, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h120,     2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[11] = mk(0, 2'b10, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h120,     2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[12] = mk(0, 2'b10, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  1, 0, 1, 28'hFFFFFF8, 2'b10, 2'b00, 2'b00, 2'b00, 0);
        vec[13] = mk(0, 2'b10, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 0, 1, 0,  0, 0, 1, 28'h0,       2'b10, 2'b00, 2'b00, 2'b00, 0);
        vec[14] = mk(0, 2'b10, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  1, 0, 1, 28'h0,       2'b10, 2'b00, 2'b00, 2'b00, 0);
        vec[15] = mk(0, 2'b10, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 0, 1, 0,  0, 0, 1, 28'h8,       2'b10, 2'b00, 2'b00, 2'b00, 0);
        vec[16] = mk(0, 2'b10, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 1,  1, 0, 1, 28'h8,       2'b10, 2'b00, 2'b10, 2'b00, 0);
        vec[17] = mk(0, 2'b00, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 1,  0, 0, 0, 28'h10,      2'b10, 2'b00, 2'b10, 2'b10, 0);
        vec[18] = mk(0, 2'b00, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 1,  0, 0, 0, 28'h10,      2'b00, 2'b00, 2'b10, 2'b00, 0);
        vec[19] = mk(0, 2'b00, 2'b00, 28'h100, 28'hFFFFFF8, 4, 3, 1, 1, 0,  0, 0, 0, 28'h10,      2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[20] = mk(0, 2'b01, 2'b01, 28'h40,  28'hFFFFFF8, 0, 3, 1, 1, 0,  0, 0, 0, 28'h10,      2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[21] = mk(0, 2'b00, 2'b01, 28'h40,  28'hFFFFFF8, 0, 3, 1, 1, 0,  0, 0, 0, 28'h40,      2'b01, 2'b00, 2'b00, 2'b01, 0);
        vec[22] = mk(0, 2'b00, 2'b00, 28'h40,  28'hFFFFFF8, 0, 3, 1, 1, 1,  0, 0, 0, 28'h40,      2'b00, 2'b00, 2'b00, 2'b00, 0);
        vec[23] = mk(0, 2'b00, 2'b00, 28'h40,  28'hFFFFFF8, 0, 3, 1, 1, 0,  0, 0, 0, 28'h40,      2'b00, 2'b00, 2'b00, 2'b00, 1);

        rst_n = 1'b0;
        init_calib_complete = 1'b0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
        req = 2'b00; req_wr = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;

        step(); step(); #1;
        chk_idle("reset", -1);
        step();
        rst_n = 1'b1;

        // Vector table: drive at the falling edge, compare just after.
        for (int i = 0; i < int'(NVEC); i++) begin
            step();
            init_calib_complete = vec[i].calib;
            req = vec[i].req; req_wr = vec[i].wr;
            req_addr0 = vec[i].a0; req_addr1 = vec[i].a1;
            req_len0 = vec[i].l0; req_len1 = vec[i].l1;
            app_rdy = vec[i].rdy; app_wdf_rdy = vec[i].wdf; app_rd_data_valid = vec[i].rdv;
            #1;
            chk("app_en", i, 32'(app_en), 32'(vec[i].en));
            chk("app_wdf_wren", i, 32'(app_wdf_wren), 32'(vec[i].wren));
            chk("app_wdf_end", i, 32'(app_wdf_end), 32'(vec[i].wren));
            chk("app_cmd", i, 32'(app_cmd), 32'(vec[i].cmd));
            chk("app_addr", i, 32'(app_addr), 32'(vec[i].addr));
            chk("gnt", i, 32'(gnt), 32'(vec[i].gnt));
            chk("wbeat", i, 32'(wbeat), 32'(vec[i].wbeat));
            chk("rd_valid", i, 32'(rd_valid), 32'(vec[i].rdo));
            chk("done", i, 32'(done), 32'(vec[i].done));
            chk("tag_err", i, 32'(tag_err), 32'(vec[i].terr));
        end

        // Contention with single-beat writes; last grant before this was port 0.
`ifdef DDR3_ARB_RR_EN
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`endif
        step();
        req = 2'b11; req_wr = 2'b11; req_addr0 = 28'h300; req_addr1 = 28'h400;
        req_len0 = 1; req_len1 = 1; app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40 && ndone < 3; c++) begin
            step(); #1;
            if (done != 2'b00) begin
                seen[ndone] = done;
                chk("gnt at done", ndone, 32'(gnt), 32'(done));
                ndone++;
                if (ndone == 3) req = 2'b00;
            end
        end
        chk("contention done count", 0, 32'(ndone), 32'd3);
        for (int k = 0; k < ndone; k++) chk("contention winner", k, 32'(seen[k]), 32'(exp_g[k]));

        // Long read with no returning data: the 32-entry tag FIFO throttles issue.
        step();
        req = 2'b01; req_wr = 2'b00; req_addr0 = 28'h0; req_len0 = 40;
        #1;
        ncmd = 0;
        for (int c = 0; c < 60; c++) begin
            step(); #1;
            if (app_en) ncmd++;
        end
        chk("reads issued before full", 0, 32'(ncmd), 32'd32);
        chk("stalled when full", 0, 32'(app_en), 32'h0);
        step(); app_rd_data_valid = 1'b1; #1;
        chk("issue on full+pop", 0, 32'(app_en), 32'h1);
        chk("rd_valid on full+pop", 0, 32'(rd_valid), 32'h1);
        if (app_en) ncmd++;
        step(); app_rd_data_valid = 1'b0; #1;
        chk("stalled again", 0, 32'(app_en), 32'h0);
        step(); app_rd_data_valid = 1'b1; #1;
        hit = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (app_en) ncmd++;
            if (done != 2'b00) begin
                hit = 1'b1;
                break;
            end
            step(); #1;
        end
        chk("long read done seen", 0, 32'(hit), 32'h1);
        chk("long read done port", 0, 32'(done), 32'h1);
        chk("long read total", 0, 32'(ncmd), 32'd40);
        req = 2'b00;

        // Reset in the middle of a port-1 write with tags still outstanding.
        step();
        app_rd_data_valid = 1'b0;
        req = 2'b10; req_wr = 2'b10; req_addr1 = 28'h200; req_len1 = 4;
        #1;
        nb = 0;
        for (int c = 0; c < 20 && nb < 2; c++) begin
            step(); #1;
            if (wbeat[1]) nb++;
        end
        chk("write beats before reset", 0, 32'(nb), 32'd2);
        rst_n = 1'b0;
        app_rd_data_valid = 1'b1;
        #1;
        chk_idle("mid-burst reset", 0);
        step(); step();
        rst_n = 1'b1;
        app_rd_data_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            chk("INIT holds gnt", c, 32'(gnt), 32'h0);
            chk("INIT holds app_en", c, 32'(app_en), 32'h0);
        end
        step(); app_rd_data_valid = 1'b1; #1;
        chk("tags discarded", 0, 32'(rd_valid), 32'h0);
        step(); app_rd_data_valid = 1'b0; #1;
        chk("tag_err after reset", 0, 32'(tag_err), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
